// File: rtl/uart_rx_framed.sv
// Oversampling 8N1 UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// one-entry VALID/READY holding register with framing-error and overrun pulses.
module uart_rx_framed #(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DIV        = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int unsigned TW = $clog2(10 * OVERSAMPLE + 1);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [DW-1:0]   div_q, div_d;
  logic [TW-1:0]   t_q, t_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            deliver_q, deliver_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;

  logic            tick;
  logic            maj;
  logic [TW-1:0]   t_nxt;
  logic [TW-1:0]   base;

  assign tick  = (div_q == DW'(DIV - 1));
  assign t_nxt = t_q + TW'(1);
  assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  // Mid-point of the bit currently being recovered, in ticks since start detection.
  always_comb begin
    case (state_q)
      StData:  base = TW'((32'(bit_q) + 1) * OVERSAMPLE + OVERSAMPLE / 2);
      StStop:  base = TW'(9 * OVERSAMPLE + OVERSAMPLE / 2);
      default: base = TW'(OVERSAMPLE / 2);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    t_d       = t_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      StIdle: begin
        div_d = '0;
        t_d   = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart, StData, StStop: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          t_d = t_nxt;
          if (t_nxt == base - TW'(1)) samp_d[0] = rx_s_q;
          if (t_nxt == base) samp_d[1] = rx_s_q;
          // Third sample is live rx_s; the vote resolves on this tick.
          if (t_nxt == base + TW'(1)) begin
            case (state_q)
              StStart: state_d = maj ? StIdle : StData;
              StData: begin
                shift_d = {maj, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = StStop;
              end
              StStop: begin
                if (maj) begin
                  state_d   = StIdle;
                  deliver_d = 1'b1;
                end else begin
                  state_d = StBreak;
                  ferr_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      StBreak: if (rx_s_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a same-cycle READY frees the slot for the incoming byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && READY) valid_d = 1'b0;
    if (deliver_q) begin
      if (!valid_q || READY) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      div_q     <= '0;
      t_q       <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      deliver_q <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      t_q       <= t_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      deliver_q <= deliver_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: directed frames, scoreboard of expected bytes popped by a
// monitor on every VALID&READY transfer, plus pulse counters for FRAME_ERR/OVERRUN.
module tb_uart_rx_framed;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          pops = 0;
  int          c0, lat;
  logic        got;
  logic [7:0]  exp_b;
  logic [7:0]  abort_b;
  logic [7:0]  sb[$];

  uart_rx_framed dut (
    .CLK      (clk),
    .RST      (rst),
    .RX       (rx),
    .DATA     (data),
    .VALID    (valid),
    .READY    (ready),
    .FRAME_ERR(ferr),
    .OVERRUN  (ovr),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(BIT);
    end
    rx = stop;
    step(BIT);
  endtask

  // Monitor: every transfer must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h, want none", data);
        end else begin
          exp_b = sb.pop_front();
          check("rx_byte", {24'd0, data}, {24'd0, exp_b});
          pops++;
        end
      end
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
    end
  end

  initial begin
    abort_b = 8'h7E;
    rst = 1'b1;
    step(4);
    check("rst_data", {24'd0, data}, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step(5);

    // 0x55 with latency measured from the first edge that samples the falling RX
    sb.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        c0  = int'(cyc) + 1;
        got = 1'b0;
        step(500);
        check("busy_mid", busy, 1);
        for (int i = 0; i < 800; i++) begin
          step(1);
          if (valid) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) begin
          n_vec++;
          n_err++;
          $display("FAIL valid_timeout: got VALID=0, want VALID=1");
        end else begin
          lat = int'(cyc) - c0;
          n_vec++;
          if (lat < 1003 || lat > 1005) begin
            n_err++;
            $display("FAIL latency: got %0d, want 1004+-1", lat);
          end
          check("busy_at_valid", busy, 0);
          check("data_55", {24'd0, data}, 32'h55);
        end
      end
    join
    step(20);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovr", ovr_cnt, 0);
    check("t1_pops", pops, 1);

    // Short low glitch: false start
    rx = 1'b0;
    step(5);
    check("glitch_busy", busy, 1);
    step(15);
    rx = 1'b1;
    step(200);
    check("glitch_idle", busy, 0);
    check("glitch_valid", valid, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);
    check("glitch_pops", pops, 1);

    // Framing error followed by a held-low break line
    send_frame(8'hA3, 1'b0);
    rx = 1'b0;
    step(3000);
    rx = 1'b1;
    step(50);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_valid", valid, 0);
    check("brk_busy", busy, 0);
    check("brk_pops", pops, 1);
    sb.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    step(30);
    check("post_brk_pops", pops, 2);
    check("post_brk_data", {24'd0, data}, 32'h0F);

    // Back-to-back frames with READY held high
    sb.push_back(8'h48);
    sb.push_back(8'h69);
    send_frame(8'h48, 1'b1);
    send_frame(8'h69, 1'b1);
    step(30);
    check("b2b_pops", pops, 4);
    check("b2b_ovr", ovr_cnt, 0);
    check("b2b_data", {24'd0, data}, 32'h69);

    // Overrun: second byte dropped while the first is unconsumed
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(30);
    check("ovr_data", {24'd0, data}, 32'h11);
    check("ovr_valid", valid, 1);
    check("ovr_cnt", ovr_cnt, 1);
    sb.push_back(8'h11);
    ready = 1'b1;
    step(1);
    check("ovr_clear", valid, 0);
    check("ovr_pops", pops, 5);
    check("ovr_hold", {24'd0, data}, 32'h11);

    // Reset in the middle of the data bits of 0x7E
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = abort_b[i];
      step(BIT);
    end
    rx = abort_b[3];
    step(50);
    check("abort_busy_pre", busy, 1);
    rst = 1'b1;
    step(1);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_data", {24'd0, data}, 0);
    rst = 1'b0;
    rx  = 1'b1;
    step(200);
    check("abort_ferr", ferr_cnt, 1);
    check("abort_ovr", ovr_cnt, 1);
    check("abort_pops", pops, 5);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    step(30);
    check("c3_pops", pops, 6);
    check("c3_data", {24'd0, data}, 32'hC3);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
